// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data-memory responder for the MEM stage.
// One request is accepted at a time over valid/ready. The access commits
// after a fixed LATENCY and a single-cycle response pulse follows. Two
// configurable word addresses are mirrored on out1/out2.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] OUT1_ADDR   = 32'h0000_0000,
   parameter logic [31:0] OUT2_ADDR   = 32'h0000_0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] out1,
   output logic [31:0] out2
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] out1_q, out1_d;
   logic [31:0] out2_q, out2_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic             commit;
   logic             acc_err;
   logic             mem_wr;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;

   // State and datapath registers; reset aborts any in-flight access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         out1_q      <= '0;
         out2_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         out1_q      <= out1_d;
         out2_q      <= out2_d;
      end
   end

   // Word storage; cleared by reset, written only by an error-free store commit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_wr) begin
         mem_q[idx] <= wdata_q;
      end
   end

   // Decode the latched access: error check, word index and commit strobe
   always_comb begin
      acc_err = (addr_q[1:0] != 2'b00) ||
                ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
      idx     = addr_q[IDX_W+1:2];
      commit  = (state_q == ST_BUSY) && (cnt_q == 4'd0);
      mem_wr  = commit && we_q && !acc_err;
      rd_word = acc_err ? '0 : mem_q[idx];
   end

   // Next-state logic: capture request in IDLE, count down in BUSY, one RESP cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_INIT;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Response and mirror registers update only on the commit edge, else hold
   always_comb begin
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      out1_d      = out1_q;
      out2_d      = out2_q;
      if (commit) begin
         rsp_err_d   = acc_err;
         rsp_rdata_d = (acc_err || we_q) ? '0 : rd_word;
         if (mem_wr && (addr_q == OUT1_ADDR)) begin
            out1_d = wdata_q;
         end
         if (mem_wr && (addr_q == OUT2_ADDR)) begin
            out2_d = wdata_q;
         end
      end
   end

   // Output decode: handshake signals follow the state, data comes from registers
   always_comb begin
      req_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
      rsp_rdata = rsp_rdata_q;
      rsp_err   = rsp_err_q;
      out1      = out1_q;
      out2      = out2_q;
   end

endmodule
